// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch display: scan states, segment
// patterns (active-low g..a), digit selects and the preset-to-BCD helper.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        S0 = 2'd0,
        S1 = 2'd1,
        S2 = 2'd2,
        S3 = 2'd3
    } scan_state_e;

    localparam logic [6:0] SEG_0   = 7'b1000000;
    localparam logic [6:0] SEG_1   = 7'b1111001;
    localparam logic [6:0] SEG_2   = 7'b0100100;
    localparam logic [6:0] SEG_3   = 7'b0110000;
    localparam logic [6:0] SEG_4   = 7'b0011001;
    localparam logic [6:0] SEG_5   = 7'b0010010;
    localparam logic [6:0] SEG_6   = 7'b0000010;
    localparam logic [6:0] SEG_7   = 7'b1111000;
    localparam logic [6:0] SEG_8   = 7'b0000000;
    localparam logic [6:0] SEG_9   = 7'b0010000;
    localparam logic [6:0] SEG_OFF = 7'b1111111;

    localparam logic [3:0] DIG_SEC_ONES = 4'b1110;
    localparam logic [3:0] DIG_SEC_TENS = 4'b1101;
    localparam logic [3:0] DIG_MIN_ONES = 4'b1011;
    localparam logic [3:0] DIG_MIN_TENS = 4'b0111;

    // Preset values above 59 saturate before conversion to packed BCD.
    function automatic logic [7:0] bin_to_bcd(input logic [5:0] v);
        logic [5:0] s;
        logic [3:0] tens;
        logic [3:0] ones;
        s    = (v > 6'd59) ? 6'd59 : v;
        tens = 4'(s / 6'd10);
        ones = 4'(s % 6'd10);
        return {tens, ones};
    endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Combinational BCD digit to active-low seven-segment (g..a) lookup.
module seg7_decoder
    import stopwatch_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_OFF;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/stopwatch_display.sv
// MM:SS up/down stopwatch with multiplexed 4-digit seven-segment output.
// Optional build macro LEADING_ZERO_BLANK_EN blanks leading minute zeros.
module stopwatch_display
    import stopwatch_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 100_000_000,
    parameter int unsigned TICK_HZ    = 1,
    parameter int unsigned REFRESH_HZ = 1000,
    parameter bit          WRAP_UP    = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       stop,
    input  logic       clear,
    input  logic       load,
    input  logic       dir,
    input  logic [5:0] load_min,
    input  logic [5:0] load_sec,
    output logic [7:0] signalout,
    output logic [3:0] digit,
    output logic [7:0] min_bcd,
    output logic [7:0] sec_bcd,
    output logic       running,
    output logic       expired
);

    localparam int unsigned TICK_DIV = CLK_HZ / TICK_HZ;
    localparam int unsigned SCAN_DIV = CLK_HZ / (REFRESH_HZ * 4);
    localparam int unsigned PW       = $clog2(TICK_DIV);
    localparam int unsigned SW       = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0] PRESC_HALF = PW'(TICK_DIV / 2);
    localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);

    logic [3:0]    s01_q, s10_q, m01_q, m10_q;
    logic [3:0]    s01_d, s10_d, m01_d, m10_d;
    logic          running_q, running_d;
    logic          expired_q, expired_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [SW-1:0] scan_cnt_q, scan_cnt_d;
    scan_state_e   scan_q, scan_d;
    logic [3:0]    digit_q, digit_d;
    logic [7:0]    signalout_q, signalout_d;

    logic          tick;
    logic          at_zero, at_one, at_max;
    logic [7:0]    load_min_bcd, load_sec_bcd;
    logic [3:0]    cur_bcd;
    logic [6:0]    cur_seg;
    logic          dp_lit;

    assign tick         = running_q && (presc_q == PRESC_LAST);
    assign at_zero      = ({m10_q, m01_q, s10_q, s01_q} == 16'h0000);
    assign at_one       = ({m10_q, m01_q, s10_q, s01_q} == 16'h0001);
    assign at_max       = ({m10_q, m01_q, s10_q, s01_q} == 16'h5959);
    assign load_min_bcd = bin_to_bcd(load_min);
    assign load_sec_bcd = bin_to_bcd(load_sec);

    // Command priority: clear > load > stop > start > tick.
    always_comb begin
        s01_d     = s01_q;
        s10_d     = s10_q;
        m01_d     = m01_q;
        m10_d     = m10_q;
        running_d = running_q;
        expired_d = expired_q;
        presc_d   = presc_q;

        if (clear) begin
            {m10_d, m01_d, s10_d, s01_d} = '0;
            running_d = 1'b0;
            expired_d = 1'b0;
            presc_d   = '0;
        end else if (load) begin
            {m10_d, m01_d} = load_min_bcd;
            {s10_d, s01_d} = load_sec_bcd;
            expired_d      = 1'b0;
            presc_d        = '0;
        end else if (stop) begin
            running_d = 1'b0;
        end else if (start) begin
            if (!(dir && at_zero)) begin
                running_d = 1'b1;
                presc_d   = '0;
            end
        end else if (running_q) begin
            if (tick) begin
                presc_d = '0;
                if (!dir) begin
                    if (at_max) begin
                        if (WRAP_UP) begin
                            {m10_d, m01_d, s10_d, s01_d} = '0;
                        end else begin
                            running_d = 1'b0;
                            expired_d = 1'b1;
                        end
                    end else if (s01_q != 4'd9) begin
                        s01_d = s01_q + 4'd1;
                    end else begin
                        s01_d = '0;
                        if (s10_q != 4'd5) begin
                            s10_d = s10_q + 4'd1;
                        end else begin
                            s10_d = '0;
                            if (m01_q != 4'd9) begin
                                m01_d = m01_q + 4'd1;
                            end else begin
                                m01_d = '0;
                                m10_d = m10_q + 4'd1;
                            end
                        end
                    end
                end else if (at_zero) begin
                    running_d = 1'b0;
                    expired_d = 1'b1;
                end else begin
                    if (at_one) begin
                        running_d = 1'b0;
                        expired_d = 1'b1;
                    end
                    if (s01_q != 4'd0) begin
                        s01_d = s01_q - 4'd1;
                    end else begin
                        s01_d = 4'd9;
                        if (s10_q != 4'd0) begin
                            s10_d = s10_q - 4'd1;
                        end else begin
                            s10_d = 4'd5;
                            if (m01_q != 4'd0) begin
                                m01_d = m01_q - 4'd1;
                            end else begin
                                m01_d = 4'd9;
                                m10_d = m10_q - 4'd1;
                            end
                        end
                    end
                end
            end else begin
                presc_d = presc_q + PW'(1);
            end
        end
    end

    always_comb begin
        scan_cnt_d = scan_cnt_q;
        scan_d     = scan_q;
        if (scan_cnt_q == SCAN_LAST) begin
            scan_cnt_d = '0;
            case (scan_q)
                S0:      scan_d = S1;
                S1:      scan_d = S2;
                S2:      scan_d = S3;
                default: scan_d = S0;
            endcase
        end else begin
            scan_cnt_d = scan_cnt_q + SW'(1);
        end
    end

    always_comb begin
        cur_bcd = s01_q;
        digit_d = DIG_SEC_ONES;
        case (scan_q)
            S0: begin cur_bcd = s01_q; digit_d = DIG_SEC_ONES; end
            S1: begin cur_bcd = s10_q; digit_d = DIG_SEC_TENS; end
            S2: begin cur_bcd = m01_q; digit_d = DIG_MIN_ONES; end
            default: begin cur_bcd = m10_q; digit_d = DIG_MIN_TENS; end
        endcase
    end

    seg7_decoder u_seg7_decoder (
        .bcd (cur_bcd),
        .seg (cur_seg)
    );

    // Colon blink: dp on the min-ones digit during the first half of each tick.
    assign dp_lit = (scan_q == S2) && running_q && (presc_q < PRESC_HALF);

    always_comb begin
        signalout_d = {~dp_lit, cur_seg};
`ifdef LEADING_ZERO_BLANK_EN
        if (((scan_q == S3) && (m10_q == 4'd0)) ||
            ((scan_q == S2) && (m10_q == 4'd0) && (m01_q == 4'd0))) begin
            signalout_d = {1'b1, SEG_OFF};
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s01_q       <= '0;
            s10_q       <= '0;
            m01_q       <= '0;
            m10_q       <= '0;
            running_q   <= 1'b0;
            expired_q   <= 1'b0;
            presc_q     <= '0;
            scan_cnt_q  <= '0;
            scan_q      <= S0;
            digit_q     <= DIG_SEC_ONES;
            signalout_q <= {1'b1, SEG_0};
        end else begin
            s01_q       <= s01_d;
            s10_q       <= s10_d;
            m01_q       <= m01_d;
            m10_q       <= m10_d;
            running_q   <= running_d;
            expired_q   <= expired_d;
            presc_q     <= presc_d;
            scan_cnt_q  <= scan_cnt_d;
            scan_q      <= scan_d;
            digit_q     <= digit_d;
            signalout_q <= signalout_d;
        end
    end

    assign signalout = signalout_q;
    assign digit     = digit_q;
    assign min_bcd   = {m10_q, m01_q};
    assign sec_bcd   = {s10_q, s01_q};
    assign running   = running_q;
    assign expired   = expired_q;

endmodule

// File: doc/stopwatch_display.md
STOPWATCH_DISPLAY -- requirements
Module: stopwatch_display

Interface
REQ-001 SHALL have parameter CLK_HZ, default 100_000_000, input clock frequency in Hz.
REQ-002 SHALL have parameter TICK_HZ, default 1, count rate in Hz; TICK_DIV = CLK_HZ/TICK_HZ, with TICK_DIV >= 2.
REQ-003 SHALL have parameter REFRESH_HZ, default 1000, full-display scan rate; SCAN_DIV = CLK_HZ/(REFRESH_HZ*4), with SCAN_DIV >= 1.
REQ-004 SHALL have parameter WRAP_UP, default 1, selecting the up-count behaviour at 59:59: 1 = wrap to 00:00, 0 = hold and set expired.
REQ-005 clk  in  1  single clock; all logic updates on its rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 start / stop / clear / load  in  1 each  single-cycle command pulses.
REQ-008 dir  in  1  count direction: 0 = up, 1 = down.
REQ-009 load_min, load_sec  in  6 each  binary preset value; values above 59 saturate to 59.
REQ-010 signalout  out  8  active-low segments: [6:0] = g..a, [7] = dp.
REQ-011 digit  out  4  active-low digit select; 1110 = sec ones, 1101 = sec tens, 1011 = min ones, 0111 = min tens.
REQ-012 min_bcd, sec_bcd  out  8 each  current time as packed BCD.
REQ-013 running, expired  out  1 each  status flags.

Function
REQ-014 The prescaler SHALL count 0..TICK_DIV-1 only while running and SHALL emit a one-cycle tick on its terminal count.
- The prescaler clears on start, load and clear.
REQ-015 Time SHALL be held as four BCD digits (s01, s10, m01, m10) and SHALL advance only on a tick.
REQ-016 Up count SHALL follow BCD rules.
- s01 9->0 carries to s10; s10 5->0 carries to m01; m01 9->0 carries to m10.
- At 59:59: WRAP_UP=1 wraps to 00:00 and keeps running; WRAP_UP=0 holds 59:59, clears running, sets expired.
REQ-017 Down count SHALL borrow symmetrically (s01 0->9, s10 0->5, and so on).
- On reaching 00:00 it clears running and sets expired in the same cycle.
- Start while at 00:00 in down mode is ignored.
REQ-018 Command priority SHALL be reset > clear > load > stop > start > tick.
- Simultaneous start and stop: stop wins.
REQ-019 clear SHALL set time 00:00, running=0, expired=0.
REQ-020 load SHALL set time from load_min/load_sec, clear expired and leave running unchanged.
REQ-021 A dir change SHALL take effect on the next tick, with no time discontinuity.
REQ-022 The scan FSM SHALL have states S0..S3 (S0->S1->S2->S3->S0), advancing once every SCAN_DIV cycles; it free-runs independent of running.
REQ-023 digit and signalout SHALL be registered and SHALL update in the same cycle, one cycle after the state change; mismatched digit/segment cycles are forbidden.
REQ-024 dp SHALL be lit only on the min-ones digit, when running and the prescaler is in the first half of the tick period (blinking colon).
REQ-025 Segment patterns (active-low, g..a) SHALL be:
- 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
- 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000

Reset
REQ-026 reset SHALL drive: time 00:00, running=0, expired=0, prescaler=0, scan state S0, scan counter 0, digit=1110, signalout=11000000.
REQ-027 reset asserted mid-count or mid-scan SHALL take effect on the next edge and override all commands.

Configuration
REQ-028 With LEADING_ZERO_BLANK_EN defined, the min-tens digit SHALL output signalout=11111111 when m10=0, and the min-ones digit likewise when m10=0 and m01=0.
- Without the macro, all digits always display.
- Status outputs are unaffected either way.

Structure
REQ-029 Package stopwatch_pkg SHALL hold the scan-state enum, the segment-pattern constants and the digit-select constants.
REQ-030 The BCD-to-segment lookup SHALL be a sub-module named seg7_decoder (purely combinational); the counters, scan FSM and output registers stay in stopwatch_display.

Verification
REQ-031 The bench SHALL cover the following, using CLK_HZ=40, TICK_HZ=1, REFRESH_HZ=10 (TICK_DIV=40, SCAN_DIV=1):
- Reset, then start, then 40*60 cycles -> sec_bcd=00, min_bcd=01, running=1.
- load 59:58 with WRAP_UP=0, dir=0, start -> 59:59 after 40 cycles; 40 more cycles -> 59:59 held, running=0, expired=1.
- load 00:02, dir=1, start -> 00:01, then 00:00 with expired=1, running=0; a further start is ignored.
- start and stop in the same cycle while running -> running=0; clear and load in the same cycle -> 00:00.
- Load 12:34 -> digit sequence 1110/1101/1011/0111 paired with the segment patterns for 4/3/2/1 in the same cycles; with LEADING_ZERO_BLANK_EN and 05:07, the min-tens digit is blank.
- reset asserted mid-tick at 00:17 -> next cycle outputs equal the REQ-026 values.
